vga_timing_generator: RTL

Generates 640x480@60 Hz VGA raster timing: horizontal/vertical sync, pixel coordinates and the visible-area enable. It sits directly upstream of every screen drawer and of the VGA interface that colours pixels, supplying their row/column/display_enable inputs. It also supplies hsync/vsync to the connector pins and per-line and per-frame strobes for game-logic pacing.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 51 +++++
 rtl/vga_timing_generator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants: default 640x480@60 porch/sync geometry and helpers
// used by the timing generator and by downstream screen drawers.
package vga_timing_pkg;

  localparam int DEFAULT_H_VISIBLE = 640;
  localparam int DEFAULT_H_FRONT   = 16;
  localparam int DEFAULT_H_SYNC    = 96;
  localparam int DEFAULT_H_BACK    = 48;

  localparam int DEFAULT_V_VISIBLE = 480;
  localparam int DEFAULT_V_FRONT   = 10;
  localparam int DEFAULT_V_SYNC    = 2;
  localparam int DEFAULT_V_BACK    = 33;

  localparam int SCREEN_WIDTH  = DEFAULT_H_VISIBLE;
  localparam int SCREEN_HEIGHT = DEFAULT_V_VISIBLE;

  // Both axis counters are 10 bits wide, so neither axis may exceed 1023 positions.
  localparam int COUNT_W   = 10;
  localparam int MAX_TOTAL = 1023;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync_w, input int back);
    return visible + front + sync_w + back;
  endfunction

  localparam int DEFAULT_H_TOTAL = axis_total(DEFAULT_H_VISIBLE, DEFAULT_H_FRONT,
                                              DEFAULT_H_SYNC, DEFAULT_H_BACK);
  localparam int DEFAULT_V_TOTAL = axis_total(DEFAULT_V_VISIBLE, DEFAULT_V_FRONT,
                                              DEFAULT_V_SYNC, DEFAULT_V_BACK);

  function automatic logic sync_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with combinational decodes of
// the wrap point, the sync window and the visible window.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEFAULT_H_VISIBLE,
  parameter int FRONT   = DEFAULT_H_FRONT,
  parameter int SYNC    = DEFAULT_H_SYNC,
  parameter int BACK    = DEFAULT_H_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic [COUNT_W-1:0] count,
  output logic               wrap,
  output logic               sync_active,
  output logic               visible
);

  localparam int TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int SYNC_START = VISIBLE + FRONT;
  localparam int SYNC_END   = SYNC_START + SYNC;

  if (TOTAL > MAX_TOTAL) begin : g_total_check
    $fatal(1, "vga_axis_counter: axis total %0d exceeds %0d", TOTAL, MAX_TOTAL);
  end

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign wrap        = (count_q == COUNT_W'(TOTAL - 1));
  assign sync_active = (count_q >= COUNT_W'(SYNC_START)) && (count_q < COUNT_W'(SYNC_END));
  assign visible     = (count_q < COUNT_W'(VISIBLE));

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: registered row/column, display enable, sync pulses and
// line/frame strobes, all decoded from the same pre-edge counter value.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE       = DEFAULT_H_VISIBLE,
  parameter int H_FRONT         = DEFAULT_H_FRONT,
  parameter int H_SYNC          = DEFAULT_H_SYNC,
  parameter int H_BACK          = DEFAULT_H_BACK,
  parameter int V_VISIBLE       = DEFAULT_V_VISIBLE,
  parameter int V_FRONT         = DEFAULT_V_FRONT,
  parameter int V_SYNC          = DEFAULT_V_SYNC,
  parameter int V_BACK          = DEFAULT_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        vga_clock,
  input  logic        reset,
  input  logic        pixel_tick,
  output logic [31:0] row,
  output logic [31:0] column,
  output logic        display_enable,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam logic SYNC_IDLE = sync_level(1'b0, SYNC_ACTIVE_LOW);

  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic               h_wrap;
  logic               h_sync_active;
  logic               h_visible;
  logic               v_wrap_unused;
  logic               v_sync_active;
  logic               v_visible;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk         (vga_clock),
    .rst_n       (reset),
    .enable      (pixel_tick),
    .count       (h_count),
    .wrap        (h_wrap),
    .sync_active (h_sync_active),
    .visible     (h_visible)
  );

  // The vertical axis advances only on the tick that wraps the horizontal axis.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk         (vga_clock),
    .rst_n       (reset),
    .enable      (pixel_tick && h_wrap),
    .count       (v_count),
    .wrap        (v_wrap_unused),
    .sync_active (v_sync_active),
    .visible     (v_visible)
  );

  logic [COUNT_W-1:0] row_q,    row_d;
  logic [COUNT_W-1:0] column_q, column_d;
  logic               display_enable_q, display_enable_d;
  logic               hsync_q,       hsync_d;
  logic               vsync_q,       vsync_d;
  logic               line_start_q,  line_start_d;
  logic               frame_start_q, frame_start_d;

  // Strobes default low so they last exactly one cycle even when ticks are sparse.
  always_comb begin
    row_d            = row_q;
    column_d         = column_q;
    display_enable_d = display_enable_q;
    hsync_d          = hsync_q;
    vsync_d          = vsync_q;
    line_start_d     = 1'b0;
    frame_start_d    = 1'b0;
    if (pixel_tick) begin
      row_d            = v_count;
      column_d         = h_count;
      display_enable_d = h_visible && v_visible;
      hsync_d          = sync_level(h_sync_active, SYNC_ACTIVE_LOW);
      vsync_d          = sync_level(v_sync_active, SYNC_ACTIVE_LOW);
      line_start_d     = (h_count == '0);
      frame_start_d    = (h_count == '0) && (v_count == '0);
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      row_q            <= '0;
      column_q         <= '0;
      display_enable_q <= 1'b0;
      hsync_q          <= SYNC_IDLE;
      vsync_q          <= SYNC_IDLE;
      line_start_q     <= 1'b0;
      frame_start_q    <= 1'b0;
    end else begin
      row_q            <= row_d;
      column_q         <= column_d;
      display_enable_q <= display_enable_d;
      hsync_q          <= hsync_d;
      vsync_q          <= vsync_d;
      line_start_q     <= line_start_d;
      frame_start_q    <= frame_start_d;
    end
  end

  assign row            = {{(32 - COUNT_W){1'b0}}, row_q};
  assign column         = {{(32 - COUNT_W){1'b0}}, column_q};
  assign display_enable = display_enable_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;

endmodule
